// File: rtl/muldiv_seq_pkg.sv
// Shared definitions for the EX-stage multiply/divide sequencer: op encodings,
// sequencer states, HI/LO result type and the stall/start level constants.
package muldiv_seq_pkg;

    localparam logic [1:0] MULDIV_MULT  = 2'b00;
    localparam logic [1:0] MULDIV_MULTU = 2'b01;
    localparam logic [1:0] MULDIV_DIV   = 2'b10;
    localparam logic [1:0] MULDIV_DIVU  = 2'b11;

    localparam logic STOP      = 1'b1;
    localparam logic NO_STOP   = 1'b0;
    localparam logic MUL_START = 1'b1;
    localparam logic DIV_START = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_DONE
    } state_e;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
    } hilo_t;

    function automatic logic is_div_op(input logic [1:0] op);
        return (op == MULDIV_DIV) || (op == MULDIV_DIVU);
    endfunction

    function automatic logic is_signed_op(input logic [1:0] op);
        return (op == MULDIV_MULT) || (op == MULDIV_DIV);
    endfunction

endpackage

// File: rtl/muldiv_seq.sv
// Launches the external multiply/divide engine for one EX request at a time,
// stalls EX until {HI,LO} is captured and holds it until the pipeline advances.
module muldiv_seq
    import muldiv_seq_pkg::*;
#(
    parameter int          TIMEOUT_CYC = 64,
    parameter logic [31:0] DIV0_LO     = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic [1:0]  req_op,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    input  logic        flush,
    input  logic        ex_advance,
    output logic        stallreq,
    output logic        res_valid,
    output logic [31:0] res_hi,
    output logic [31:0] res_lo,
    output logic        div0,
    output logic        timeout,
    output logic        mul_start,
    output logic        mul_signed,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    input  logic [63:0] mul_result,
    input  logic        mul_ready,
    output logic        div_start,
    output logic        div_signed,
    output logic        div_annul,
    output logic [31:0] div_a,
    output logic [31:0] div_b,
    input  logic [63:0] div_result,
    input  logic        div_ready
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC);

    state_e           state_q;
    logic [1:0]       op_q;
    logic [31:0]      a_q;
    logic [31:0]      b_q;
    logic [CNT_W-1:0] cnt_q;
    hilo_t            res_q;
    logic             res_valid_q;
    logic             div0_q;
    logic             timeout_q;
    logic             mul_start_q;
    logic             div_start_q;
    logic             sel_ready;

    // start flags are high exactly while BUSY, so they also select the engine
    assign sel_ready = (mul_start_q & mul_ready) | (div_start_q & div_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            cnt_q       <= '0;
            res_q       <= '0;
            res_valid_q <= 1'b0;
            div0_q      <= 1'b0;
            timeout_q   <= 1'b0;
            mul_start_q <= 1'b0;
            div_start_q <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (req_valid && !flush) begin
                        op_q  <= req_op;
                        a_q   <= req_a;
                        b_q   <= req_b;
                        cnt_q <= '0;
                        if (is_div_op(req_op) && (req_b == 32'd0)) begin
                            res_q       <= '{hi: req_a, lo: DIV0_LO};
                            div0_q      <= 1'b1;
                            res_valid_q <= 1'b1;
                            state_q     <= ST_DONE;
                        end else begin
                            mul_start_q <= is_div_op(req_op) ? 1'b0 : MUL_START;
                            div_start_q <= is_div_op(req_op) ? DIV_START : 1'b0;
                            state_q     <= ST_BUSY;
                        end
                    end
                end
                ST_BUSY: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (flush) begin
                        mul_start_q <= 1'b0;
                        div_start_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end else if (sel_ready) begin
                        res_q       <= div_start_q ? div_result : mul_result;
                        res_valid_q <= 1'b1;
                        div0_q      <= 1'b0;
                        mul_start_q <= 1'b0;
                        div_start_q <= 1'b0;
                        state_q     <= ST_DONE;
                    end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                        res_q       <= '0;
                        res_valid_q <= 1'b1;
                        div0_q      <= 1'b0;
                        timeout_q   <= 1'b1;
                        mul_start_q <= 1'b0;
                        div_start_q <= 1'b0;
                        state_q     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (flush || ex_advance) begin
                        res_valid_q <= 1'b0;
                        div0_q      <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign stallreq   = (req_valid && !flush && (state_q != ST_DONE)) ? STOP : NO_STOP;
    assign res_valid  = res_valid_q;
    assign res_hi     = res_q.hi;
    assign res_lo     = res_q.lo;
    assign div0       = div0_q;
    assign timeout    = timeout_q;

    assign mul_start  = mul_start_q;
    assign mul_signed = mul_start_q & is_signed_op(op_q);
    assign mul_a      = mul_start_q ? a_q : 32'd0;
    assign mul_b      = mul_start_q ? b_q : 32'd0;

    assign div_start  = div_start_q;
    assign div_signed = div_start_q & is_signed_op(op_q);
    assign div_annul  = div_start_q & flush;
    assign div_a      = div_start_q ? a_q : 32'd0;
    assign div_b      = div_start_q ? b_q : 32'd0;

endmodule
